// File: rtl/pipe4_hazard_ctrl_pkg.sv
// Shared encodings for the 4-stage pipeline hazard controller.
package pipe4_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  // Operand source selects driven to the datapath bypass muxes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  // RUN: pipeline flows; MULWAIT: a multiply is occupying EX.
  typedef enum logic {
    RUN     = 1'b0,
    MULWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe4_hazard_ctrl_fwd_sel.sv
// Per-operand bypass select: EX result beats WB result, r0 never bypasses.
module pipe4_fwd_sel
  import pipe4_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic              ex_valid,
  input  logic              ex_wen,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_ready,
  input  logic              wb_valid,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd
);

  // A match on an unfinished EX result selects nothing; the pipe is stalled then.
  always_comb begin
    fwd = FWD_RF;
    if (use_rs && (rs != '0)) begin
      if (ex_valid && ex_wen && (ex_rd == rs)) begin
        fwd = ex_ready ? FWD_EX : FWD_RF;
      end else if (wb_valid && wb_wen && (wb_rd == rs)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe4_hazard_ctrl.sv
// Hazard and sequencing control for the IF/ID/EX/WB pipeline.
// imem_ready is a plain qualifier: fetch data is used only in a cycle where it
// is 1; this block never pushes back on instruction memory.
module pipe4_hazard_ctrl
  import pipe4_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_mul,
  input  logic              ex_branch_taken,
  input  logic              imem_ready,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output state_t            dbg_state
);

  localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [MCW-1:0] MCNT_INIT = MCW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  state_t              state, state_nx;
  logic [MCW-1:0]      mcnt, mcnt_nx;
  logic                ex_valid, ex_wen, ex_mul;
  logic [REG_AW-1:0]   ex_rd;
  logic                wb_valid, wb_wen;
  logic [REG_AW-1:0]   wb_rd;
  logic                ex_valid_nx, ex_wen_nx, ex_mul_nx;
  logic [REG_AW-1:0]   ex_rd_nx;
  logic                wb_valid_nx, wb_wen_nx;
  logic [REG_AW-1:0]   wb_rd_nx;
  logic                branch, mulwait, issue;
  logic [1:0]          fwd_a_raw, fwd_b_raw;

  assign mulwait   = (state == MULWAIT);
  assign branch    = ex_branch_taken && ex_valid && !mulwait;
  assign issue     = id_valid && idex_en && !idex_flush;
  assign dbg_state = state;

  // Stage enables and flushes; everything is forced idle while in reset.
  always_comb begin
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b1;
    idex_en       = 1'b0;
    idex_flush    = 1'b1;
    ex_busy       = 1'b0;
    if (rst) begin
      if (branch) begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
      end else if (mulwait) begin
        ex_busy    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
      end else if (!imem_ready) begin
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
      end
    end
  end

  pipe4_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs(id_rs1), .use_rs(id_use_rs1),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_ready(!mulwait),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .fwd(fwd_a_raw)
  );

  pipe4_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs(id_rs2), .use_rs(id_use_rs2),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_ready(!mulwait),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .fwd(fwd_b_raw)
  );

  assign fwd_a = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst ? fwd_b_raw : FWD_RF;

  // Next FSM state, multiply countdown and scoreboard slot contents.
  always_comb begin
    state_nx    = state;
    mcnt_nx     = mcnt;
    ex_valid_nx = ex_valid;
    ex_rd_nx    = ex_rd;
    ex_wen_nx   = ex_wen;
    ex_mul_nx   = ex_mul;
    wb_valid_nx = wb_valid;
    wb_rd_nx    = wb_rd;
    wb_wen_nx   = wb_wen;
    if (mulwait) begin
      wb_valid_nx = 1'b0;
      if (mcnt == '0) begin
        state_nx = RUN;
      end else begin
        mcnt_nx = mcnt - 1'b1;
      end
    end else begin
      wb_valid_nx = ex_valid;
      wb_rd_nx    = ex_rd;
      wb_wen_nx   = ex_wen;
      ex_valid_nx = issue;
      ex_rd_nx    = id_rd;
      ex_wen_nx   = issue && id_wen;
      ex_mul_nx   = issue && id_is_mul;
      if (issue && id_is_mul && (MUL_LAT > 1)) begin
        state_nx = MULWAIT;
        mcnt_nx  = MCNT_INIT;
      end
    end
  end

  // State register and scoreboard slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      mcnt     <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_wen   <= 1'b0;
      ex_mul   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
    end else begin
      state    <= state_nx;
      mcnt     <= mcnt_nx;
      ex_valid <= ex_valid_nx;
      ex_rd    <= ex_rd_nx;
      ex_wen   <= ex_wen_nx;
      ex_mul   <= ex_mul_nx;
      wb_valid <= wb_valid_nx;
      wb_rd    <= wb_rd_nx;
      wb_wen   <= wb_wen_nx;
    end
  end

  // Saturating stall and branch-flush counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ifid_en && !ifid_flush && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (branch && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe4_hazard_ctrl.sv
// Directed bench for pipe4_hazard_ctrl: forwarding, multiply stall, branch
// flush, fetch wait, reset abort and counter saturation.
module tb_pipe4_hazard_ctrl;
  import pipe4_hazard_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;

  // {pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush, ex_busy}
  localparam logic [6:0] C_RST = 7'b0001010;
  localparam logic [6:0] C_RUN = 7'b1010100;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_MUL = 7'b0000001;
  localparam logic [6:0] C_IFW = 7'b0011100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wen = 1'b0, id_is_mul = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          imem_ready = 1'b1;
  logic          pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush, ex_busy;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  state_t        dbg_state;
  logic [6:0]    ctl;

  int checks = 0;
  int failures = 0;

  assign ctl = {pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_en, idex_flush, ex_busy};

  pipe4_hazard_ctrl #(.REG_AW(AW), .MUL_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_mul(id_is_mul), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_busy(ex_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic u1,
                        input logic [AW-1:0] rs2, input logic u2,
                        input logic [AW-1:0] rd, input logic wen, input logic mul);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_wen = wen; id_is_mul = mul;
  endtask

  task automatic idle_id();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; ex_branch_taken = 1'b0; imem_ready = 1'b1;
    idle_id();
    repeat (3) cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ctl !== C_RST) begin failures++; $display("FAIL reset_ctl cyc%0d got=%b exp=%b", i, ctl, C_RST); end
      checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
      checks++; if ({stall_cnt, flush_cnt} !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      cyc();
    end
    rst = 1'b1;
    idle_id();
    @(negedge clk);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL reset_release got=%b exp=%b", ctl, C_RUN); end
    checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL reset_state got=%0d exp=RUN", dbg_state); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);           // add r3,r1,r2
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL fwd_first got=%b exp=0000", {fwd_a, fwd_b}); end
    cyc();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);           // add r4,r3,r3
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin failures++; $display("FAIL fwd_ex_both got=%b exp=0101", {fwd_a, fwd_b}); end
    cyc();
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);           // add r5,r3,r0
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b1000) begin failures++; $display("FAIL fwd_wb_r0 got=%b exp=1000", {fwd_a, fwd_b}); end
    cyc();
    set_id(1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0);           // add r0,r4,r5
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin failures++; $display("FAIL fwd_mix got=%b exp=1001", {fwd_a, fwd_b}); end
    cyc();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);           // r0 in EX with wen
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL fwd_r0_ex got=%b exp=0000", {fwd_a, fwd_b}); end
    cyc();
    set_id(1'b1, 5'd6, 1'b1, 5'd6, 1'b0, 5'd6, 1'b1, 1'b0);           // r6 in EX and WB
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0100) begin failures++; $display("FAIL fwd_ex_prio_use got=%b exp=0100", {fwd_a, fwd_b}); end
    cyc();
    idle_id();
  endtask

  task automatic test_mul();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);           // mul r5
    @(negedge clk);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL mul_issue got=%b exp=%b", ctl, C_RUN); end
    cyc();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);           // add r6,r5
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ctl !== C_MUL) begin failures++; $display("FAIL mul_wait cyc%0d got=%b exp=%b", i, ctl, C_MUL); end
      cyc();
    end
    @(negedge clk);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL mul_done got=%b exp=%b", ctl, C_RUN); end
    checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL mul_dep_fwd got=%b exp=01", fwd_a); end
    checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL mul_stall_cnt got=%0d exp=3", stall_cnt); end
    cyc();
    set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b1001) begin failures++; $display("FAIL mul_wb_fwd got=%b exp=1001", {fwd_a, fwd_b}); end
    checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL mul_stall_hold got=%0d exp=3", stall_cnt); end
    cyc();
    idle_id();
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);           // add r7 (branch)
    cyc();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);           // wrong-path add r8,r7
    ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== C_BR) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BR); end
    checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL br_fwd got=%b exp=01", fwd_a); end
    cyc();
    set_id(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0010) begin failures++; $display("FAIL br_bubble_fwd got=%b exp=0010", {fwd_a, fwd_b}); end
    checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL br_on_bubble got=%b exp=%b", ctl, C_RUN); end
    cyc();
    ex_branch_taken = 1'b0;
    idle_id();
    @(negedge clk);
    checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL br_bubble_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    imem_ready = 1'b0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);           // add r9
    @(negedge clk);
    checks++; if (ctl !== C_IFW) begin failures++; $display("FAIL ifw_c0 got=%b exp=%b", ctl, C_IFW); end
    cyc();
    set_id(1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (ctl !== C_IFW) begin failures++; $display("FAIL ifw_c1 got=%b exp=%b", ctl, C_IFW); end
    checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL ifw_advance got=%b exp=01", fwd_a); end
    cyc();
    imem_ready = 1'b1;
    @(negedge clk);
    checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL ifw_wb got=%b exp=10", fwd_a); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL ifw_stall_cnt got=%0d exp=0", stall_cnt); end
    cyc();
    idle_id();
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);           // mul r5
    cyc();
    idle_id();
    @(negedge clk);
    checks++; if (ex_busy !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", ex_busy); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (ctl !== C_RST) begin failures++; $display("FAIL abort_ctl got=%b exp=%b", ctl, C_RST); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL abort_cnt got=%0d exp=0", stall_cnt); end
    cyc();
    cyc();
    rst = 1'b1;
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL abort_release got=%b exp=%b", ctl, C_RUN); end
    checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL abort_state got=%0d exp=RUN", dbg_state); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL abort_slots got=%b exp=0000", {fwd_a, fwd_b}); end
    checks++; if ({stall_cnt, flush_cnt} !== '0) begin failures++; $display("FAIL abort_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    cyc();
    idle_id();
    @(negedge clk);
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL abort_residual got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int m = 0; m < 6; m++) begin
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
      cyc();
      idle_id();
      repeat (3) cyc();
      if (m == 4) begin
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_15 got=%0d exp=15", stall_cnt); end
      end
    end
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_hold got=%0d exp=15", stall_cnt); end
    for (int b = 0; b < 17; b++) begin
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0);
      cyc();
      ex_branch_taken = 1'b1;
      cyc();
      ex_branch_taken = 1'b0;
    end
    idle_id();
    @(negedge clk);
    checks++; if (flush_cnt !== 4'd15) begin failures++; $display("FAIL sat_flush got=%0d exp=15", flush_cnt); end
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_final got=%0d exp=15", stall_cnt); end
  endtask

  // Test sequence and summary
  initial begin
    test_reset();
    test_forward();
    test_mul();
    test_branch();
    test_fetch_wait();
    test_reset_mid_mul();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
